pcs_sync_fsm_param: RTL and testbench

//  Parametrised 1000BASE-X PCS receive synchroniser (clause-36 style).
//  - Sits between the 10-bit deserialiser/aligner and the PCS receive state machine.
//  - Acquires sync after a configurable number of even-aligned commas.
//  - Tolerates isolated code-group errors through an error/good-group hysteresis counter.
//  - Qualifies input with a valid strobe and tracks even/odd code-group parity (RX_EVEN).

---
 rtl/pcs_sync_fsm_param.sv | 158 +++++++++++++++
 tb/tb_pcs_sync_fsm_param.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pcs_sync_fsm_param.sv
// 1000BASE-X PCS receive synchroniser: comma acquisition, error hysteresis, RX_EVEN tracking.
// Optional running-disparity validity check is enabled by defining RUNNING_DISPARITY_CHECK_EN.
//
// state          | meaning
// LOSS_OF_SYNC   | hunting for a comma, output forced to 0
// COMMA_DETECT   | comma seen, expecting a data group next
// ACQUIRE_SYNC   | counting even-aligned commas toward sync
// SYNC_ACQUIRED  | in sync, groups passed through, errors counted
module pcs_sync_fsm_param #(
    parameter int ACQ_COMMAS   = 3,
    parameter int LOSS_ERRORS  = 4,
    parameter int GOOD_RECOVER = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_cg_valid,
    input  logic [9:0] rx_code_group_in,
    output logic [9:0] rx_code_group_out,
    output logic       rx_cg_out_valid,
    output logic       RX_EVEN,
    output logic       sync_status,
    output logic [2:0] err_count
);

    localparam logic [2:0] ACQ_C  = 3'(ACQ_COMMAS);
    localparam logic [2:0] LOSS_C = 3'(LOSS_ERRORS);
    localparam logic [3:0] GOOD_C = 4'(GOOD_RECOVER);

    typedef enum logic [1:0] {
        LOSS_OF_SYNC,
        COMMA_DETECT,
        ACQUIRE_SYNC,
        SYNC_ACQUIRED
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] comma_cnt_q, comma_cnt_d;
    logic [3:0] good_cnt_q, good_cnt_d;
    logic [2:0] err_cnt_d;
    logic       rx_even_d;
    logic       go_loss;

    logic [3:0] ones;
    logic [3:0] run_cur, run_max;
    logic       is_comma, is_valid, is_data, disp_bad;

    always_comb begin
        ones    = '0;
        run_cur = 4'd1;
        run_max = 4'd1;
        for (int i = 0; i < 10; i++) ones = ones + {3'b000, rx_code_group_in[i]};
        for (int i = 1; i < 10; i++) begin
            run_cur = (rx_code_group_in[i] == rx_code_group_in[i-1]) ? run_cur + 4'd1 : 4'd1;
            if (run_cur > run_max) run_max = run_cur;
        end
    end

`ifdef RUNNING_DISPARITY_CHECK_EN
    logic rd_q;  // 1 = positive running disparity

    assign disp_bad = (ones == 4'd6 && rd_q) || (ones == 4'd4 && !rd_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_q <= 1'b0;
        else if (rx_cg_valid && ones != 4'd5) rd_q <= (ones > 4'd5);
    end
`else
    assign disp_bad = 1'b0;
`endif

    assign is_comma = (rx_code_group_in == 10'b0011111010) || (rx_code_group_in == 10'b1100000101);
    assign is_valid = is_comma ||
                      (ones >= 4'd4 && ones <= 4'd6 && run_max <= 4'd4 && !disp_bad);
    assign is_data  = is_valid && !is_comma;

    always_comb begin
        state_d     = state_q;
        comma_cnt_d = comma_cnt_q;
        good_cnt_d  = good_cnt_q;
        err_cnt_d   = err_count;
        rx_even_d   = !RX_EVEN;
        go_loss     = 1'b0;
        case (state_q)
            LOSS_OF_SYNC: begin
                if (is_comma) begin
                    state_d     = COMMA_DETECT;
                    rx_even_d   = 1'b1;
                    comma_cnt_d = 3'd1;
                end
            end
            COMMA_DETECT: begin
                if (is_data) begin
                    state_d   = ACQUIRE_SYNC;
                    rx_even_d = 1'b0;
                end else begin
                    go_loss = 1'b1;
                end
            end
            ACQUIRE_SYNC: begin
                if (is_comma && !RX_EVEN) begin
                    comma_cnt_d = comma_cnt_q + 3'd1;
                    rx_even_d   = 1'b1;
                    state_d     = (comma_cnt_q + 3'd1 == ACQ_C) ? SYNC_ACQUIRED : COMMA_DETECT;
                end else if (!is_data) begin
                    go_loss = 1'b1;
                end
            end
            SYNC_ACQUIRED: begin
                if (is_comma) rx_even_d = 1'b1;
                // an error always wins over a pending recovery step
                if (!is_valid || (is_comma && RX_EVEN)) begin
                    good_cnt_d = 4'd0;
                    if (err_count + 3'd1 == LOSS_C) go_loss = 1'b1;
                    else                             err_cnt_d = err_count + 3'd1;
                end else if (err_count != 3'd0) begin
                    if (good_cnt_q + 4'd1 == GOOD_C) begin
                        err_cnt_d  = err_count - 3'd1;
                        good_cnt_d = 4'd0;
                    end else begin
                        good_cnt_d = good_cnt_q + 4'd1;
                    end
                end
            end
            default: go_loss = 1'b1;
        endcase
        if (go_loss) begin
            state_d     = LOSS_OF_SYNC;
            comma_cnt_d = 3'd0;
            good_cnt_d  = 4'd0;
            err_cnt_d   = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= LOSS_OF_SYNC;
            comma_cnt_q       <= 3'd0;
            good_cnt_q        <= 4'd0;
            err_count         <= 3'd0;
            RX_EVEN           <= 1'b0;
            rx_code_group_out <= 10'd0;
            rx_cg_out_valid   <= 1'b0;
            sync_status       <= 1'b0;
        end else begin
            rx_cg_out_valid <= rx_cg_valid;
            if (rx_cg_valid) begin
                state_q           <= state_d;
                comma_cnt_q       <= comma_cnt_d;
                good_cnt_q        <= good_cnt_d;
                err_count         <= err_cnt_d;
                RX_EVEN           <= rx_even_d;
                rx_code_group_out <= (state_q == SYNC_ACQUIRED) ? rx_code_group_in : 10'd0;
                sync_status       <= (state_d == SYNC_ACQUIRED);
            end
        end
    end

endmodule

// File: tb/tb_pcs_sync_fsm_param.sv
// Scoreboard bench for pcs_sync_fsm_param: directed scenarios plus randomized code-group streams.
module tb_pcs_sync_fsm_param;

    localparam int ACQ = 3, LOSSE = 4, GOODR = 3;
    localparam logic [9:0] KM = 10'b0011111010, KP = 10'b1100000101, D56 = 10'b1010010110;
    localparam logic [9:0] BAD = 10'b1111111111, W4 = 10'b0100101010;

    logic       clk = 1'b0, reset = 1'b0, rx_cg_valid = 1'b0;
    logic [9:0] rx_code_group_in = '0, rx_code_group_out;
    logic       rx_cg_out_valid, RX_EVEN, sync_status;
    logic [2:0] err_count;

    pcs_sync_fsm_param #(.ACQ_COMMAS(ACQ), .LOSS_ERRORS(LOSSE), .GOOD_RECOVER(GOODR)) dut (
        .clk(clk), .reset(reset), .rx_cg_valid(rx_cg_valid), .rx_code_group_in(rx_code_group_in),
        .rx_code_group_out(rx_code_group_out), .rx_cg_out_valid(rx_cg_out_valid),
        .RX_EVEN(RX_EVEN), .sync_status(sync_status), .err_count(err_count));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] out;
        logic       sync;
        logic [2:0] err;
        logic       even;
    } exp_t;

    exp_t q[$];
    exp_t last_exp = '0;
    int   errors = 0, checks = 0;

    // reference model: the link is described by a phase name and counters
    string m_phase = "hunt";
    int    m_commas = 0, m_errs = 0, m_goods = 0;
    bit    m_even = 0, m_rd_pos = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit has_long_run(input logic [9:0] w);
        for (int i = 0; i <= 5; i++)
            if (w[i +: 5] == 5'b00000 || w[i +: 5] == 5'b11111) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_phase = "hunt"; m_commas = 0; m_errs = 0; m_goods = 0; m_even = 0; m_rd_pos = 0;
        q.delete();
        last_exp = '0;
    endtask

    task automatic model_step(input logic [9:0] w);
        int   n;
        bit   comma, valid, data, lose;
        exp_t e;
        n     = $countones(w);
        comma = (w == KM) || (w == KP);
        valid = comma || (n >= 4 && n <= 6 && !has_long_run(w));
`ifdef RUNNING_DISPARITY_CHECK_EN
        if (!comma && ((n == 6 && m_rd_pos) || (n == 4 && !m_rd_pos))) valid = 0;
        if (n != 5) m_rd_pos = (n > 5);
`endif
        data  = valid && !comma;
        e.out = (m_phase == "sync") ? w : 10'd0;
        lose  = 0;
        if (m_phase == "hunt") begin
            if (comma) begin m_phase = "comma"; m_even = 1; m_commas = 1; end
            else m_even = !m_even;
        end else if (m_phase == "comma") begin
            if (data) begin m_phase = "acquire"; m_even = 0; end
            else begin lose = 1; m_even = !m_even; end
        end else if (m_phase == "acquire") begin
            if (comma && !m_even) begin
                m_commas++; m_even = 1;
                m_phase = (m_commas == ACQ) ? "sync" : "comma";
            end else begin
                if (!data) lose = 1;
                m_even = !m_even;
            end
        end else begin
            if (!valid || (comma && m_even)) begin
                m_goods = 0;
                if (m_errs + 1 == LOSSE) lose = 1; else m_errs++;
            end else if (m_errs > 0) begin
                m_goods++;
                if (m_goods == GOODR) begin m_errs--; m_goods = 0; end
            end
            m_even = comma ? 1'b1 : !m_even;
        end
        if (lose) begin m_phase = "hunt"; m_commas = 0; m_goods = 0; m_errs = 0; end
        e.sync = (m_phase == "sync");
        e.err  = 3'(m_errs);
        e.even = m_even;
        q.push_back(e);
    endtask

    task automatic send(input logic [9:0] w);
        @(posedge clk); #1;
        rx_cg_valid = 1'b1;
        rx_code_group_in = w;
        model_step(w);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; rx_cg_valid = 1'b0; rx_code_group_in = 10'($urandom); end
    endtask

    task automatic check_after(input string name, input int exp_sync, input int exp_err);
        idle(1);
        @(negedge clk);
        chk({name, "_sync"}, sync_status, exp_sync);
        chk({name, "_err"}, err_count, exp_err);
    endtask

    task automatic acquire();
        send(KM); send(D56); send(KP); send(D56); send(KM);
    endtask

    always @(negedge clk) begin
        if (rx_cg_out_valid) begin
            if (q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                last_exp = q.pop_front();
                chk("sb_out", rx_code_group_out, last_exp.out);
                chk("sb_sync", sync_status, last_exp.sync);
                chk("sb_err", err_count, last_exp.err);
                chk("sb_even", RX_EVEN, last_exp.even);
            end
        end else if (reset) begin
            chk("hold_out", rx_code_group_out, last_exp.out);
            chk("hold_sync", sync_status, last_exp.sync);
            chk("hold_err", err_count, last_exp.err);
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", rx_code_group_out, 0);
        chk("rst_vld", rx_cg_out_valid, 0);
        chk("rst_even", RX_EVEN, 0);
        chk("rst_sync", sync_status, 0);
        chk("rst_err", err_count, 0);
        #2 reset = 1'b1;

        send(KM); send(D56); send(KP); send(D56);
        check_after("t1_pre", 0, 0);
        send(KM);
        check_after("t1_sync", 1, 0);
        send(D56);

        send(BAD);
        check_after("t3_err", 1, 1);
        send(D56); send(D56); send(D56);
        check_after("t3_rec", 1, 0);

        send(BAD);
        idle(5);
        @(negedge clk);
        chk("t5_vld", rx_cg_out_valid, 0);
        chk("t5_err", err_count, 1);
        send(D56); send(D56); send(D56);

        send(BAD); send(BAD); send(BAD);
        check_after("t2_err3", 1, 3);
        send(BAD);
        check_after("t2_loss", 0, 0);

        send(KM); send(D56); send(D56); send(KP);
        check_after("t4_odd_comma", 0, 0);

        acquire();
        send(D56); send(KP); send(W4);
`ifdef RUNNING_DISPARITY_CHECK_EN
        check_after("t6_disp", 1, 1);
`else
        check_after("t6_disp", 1, 0);
`endif

        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (i == 300) begin
                idle(2);
                #2 reset = 1'b0;
                #1;
                chk("async_rst_out", rx_code_group_out, 0);
                chk("async_rst_sync", sync_status, 0);
                chk("async_rst_err", err_count, 0);
                model_reset();
                @(negedge clk); #2 reset = 1'b1;
            end
            if (r < 8)       acquire();
            else if (r < 20) idle(int'($urandom_range(1, 3)));
            else if (r < 35) send($urandom_range(0, 1) ? KM : KP);
            else if (r < 60) send(D56);
            else if (r < 70) send(W4);
            else if (r < 75) send(BAD);
            else if (r < 85) send(10'b1010101010);
            else             send(10'($urandom));
        end

        idle(3);
        @(negedge clk);
        chk("sb_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
